// File: rtl/counter_pkg.sv
// Shared constants and types for the range up/down counter family.
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/counter_prescaler.sv
// Enable-qualified prescaler: tick is high when the phase counter has reached div,
// and the counter returns to zero on that enabled cycle.
module counter_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] pre_d;

  assign tick = (pre_q == div);

  // Phase advances only on enabled cycles, so en=0 preserves the phase.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/counter_range_updown.sv
// Range-bounded up/down counter with wrap/saturate, terminal-count pulse and sticky overflow.
// Optional prescaler on the step qualifier is enabled with the COUNTER_PRESCALE_EN macro.
module counter_range_updown
  import counter_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [N-1:0]          load_value,
  input  logic [N-1:0]          limit,
  input  logic                  dir,
  input  logic                  mode,
  input  logic                  clr_ovf,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale_div,
`endif
  output logic [N-1:0]          count,
  output logic                  tc,
  output logic                  ovf
);

  if (N < 2) begin : g_bad_n
    $error("counter_range_updown: N must be at least 2");
  end
  if (PRESCALE_W == 0) begin : g_bad_prescale_w
    $error("counter_range_updown: PRESCALE_W must be at least 1");
  end

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;
  logic         tc_q;
  logic         tc_d;
  logic         ovf_q;
  logic         ovf_d;
  logic         tick;
  logic         step;
  logic         at_bound;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clr     (load),
    .div     (prescale_div),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign step = en & tick;

  // Inclusive compares keep count bounded even when it sits outside the range.
  assign at_bound = (dir == DIR_UP) ? (count_q >= limit) : (count_q <= load_value);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (load) begin
      count_d = load_value;
    end else if (step) begin
      if (!at_bound) begin
        count_d = (dir == DIR_UP) ? count_q + N'(1) : count_q - N'(1);
      end else begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (mode_e'(mode) == MODE_WRAP) begin
          count_d = (dir == DIR_UP) ? load_value : limit;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/counter_range_updown.md
Name: counter_range_updown

Overview:
- Parametrised successor of the team's loadable N-bit counter.
- Adds the following:
  - up/down direction
  - a programmable upper limit with `load_value` as the lower bound/base
  - wrap or saturate mode
  - count enable
  - a registered terminal-count pulse
  - a sticky overflow flag
- Used as a general timer/event counter in control paths.
- With `dir`=up, wrap mode, `en`=1 and `limit`=all-ones, it behaves like the earlier loadable counter, except that reset is active-low.

Parameters:
- N, 8, counter width in bits (N >= 2)
- PRESCALE_W, 4, width of prescaler divide value; used only when COUNTER_PRESCALE_EN is defined

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- en  input  1  count enable; one step per qualified cycle
- load  input  1  synchronous load of `load_value` into `count`
- load_value  input  N  load value; also the lower bound (base) of the count range
- limit  input  N  upper bound of the count range
- dir  input  1  1 = count up, 0 = count down
- mode  input  1  0 = wrap, 1 = saturate
- clr_ovf  input  1  synchronous clear of `ovf`
- count  output  N  current count (registered)
- tc  output  1  terminal-count pulse (registered, 1 cycle)
- ovf  output  1  sticky boundary-hit flag (registered)

Behaviour:
- Reset (`reset_n`=0, asynchronous): `count`=0, `tc`=0, `ovf`=0, prescaler=0. Release is synchronous to `clk`.
- Step qualifier:
  - step = `en` & tick.
  - tick=1 always, unless COUNTER_PRESCALE_EN is defined.
- Priority per cycle: reset > load > step > hold.
- Load:
  - `count` <= `load_value`; `tc` <= 0.
  - Prescaler cleared.
  - Any step in the same cycle is discarded.
- Up step (`dir`=1):
  - Boundary when `count` >= `limit` (unsigned).
  - Not at boundary: `count` <= `count`+1, `tc` <= 0.
  - At boundary, wrap: `count` <= `load_value`.
  - At boundary, saturate: `count` holds.
  - Either boundary case: `tc` <= 1, `ovf` <= 1.
- Down step (`dir`=0):
  - Boundary when `count` <= `load_value` (unsigned).
  - Not at boundary: `count` <= `count`-1.
  - At boundary, wrap: `count` <= `limit`.
  - At boundary, saturate: `count` holds.
  - Either boundary case: `tc` <= 1, `ovf` <= 1.
- No step and no load: `count` holds, `tc` <= 0.
- `tc` is high exactly one cycle after each boundary step. Consecutive boundary steps in saturate mode give consecutive `tc` pulses.
- `ovf`:
  - Set by any boundary step; cleared by `clr_ovf`.
  - If set and clear occur in the same cycle, set wins.
  - Load does not clear `ovf`.
- Inputs are sampled each cycle:
  - `dir`, `mode`, `limit`, `load_value` may change at any time and take effect at the next edge.
  - The >=/<= comparisons keep `count` bounded even if `count` is outside [`load_value`, `limit`].
- `load_value` == `limit`: every step is a boundary step; `count` is set to that value.
- `load_value` > `limit` (empty range):
  - up wrap: `count` <= `load_value`.
  - down wrap: `count` <= `limit`.
  - `tc` fires on every step; no error signalled.
- Arithmetic is N-bit unsigned; +1/-1 never wraps through 2^N because of the boundary checks.

Optional Feature:
- Macro COUNTER_PRESCALE_EN.
- Defined:
  - Adds input port `prescale_div` [PRESCALE_W-1:0] and an internal PRESCALE_W-bit prescaler.
  - The prescaler increments on each `en` cycle.
  - tick=1 when prescaler == `prescale_div`, and the prescaler then returns to 0.
  - Result: one step per (`prescale_div`+1) enabled cycles.
  - `prescale_div`=0 gives a step every enabled cycle.
  - Prescaler cleared by reset and load; holds when `en`=0.
- Not defined: `prescale_div` port absent; tick=1.

Decomposition:
- Shared package `counter_pkg`:
  - constants DIR_DOWN=0, DIR_UP=1, MODE_WRAP=0, MODE_SAT=1.
  - typedef for mode.
- Sub-module `counter_prescaler` (PRESCALE_W parameter; ports clk, reset_n, en, clr, div, tick), instantiated only under COUNTER_PRESCALE_EN.
- Next-state/boundary logic stays in the top level.

Test Plan:
- N=8, `reset_n` pulsed low mid-count at 0x37 -> `count`, `tc`, `ovf` go to 0 immediately (asynchronously), with no clock edge needed.
- Up wrap, `load_value`=3, `limit`=6, `en`=1 after load -> `count` 3,4,5,6,3,4; `tc` high only in the cycle after 6→3; `ovf`=1 thereafter.
- Down saturate, `load_value`=2, `limit`=9, load then 9 steps -> `count` 2 (after load), 2 (held); `tc` high on each step at 2; `clr_ovf` with no boundary -> `ovf`=0.
- `load`=1 and `en`=1 with `count`=`limit` in wrap mode -> `count`=`load_value`, `tc`=0; simultaneous `clr_ovf` and boundary step -> `ovf` stays 1.
- `limit` lowered from 200 to 10 while `count`=50, up wrap -> next step `count`=`load_value`, `tc`=1.
- COUNTER_PRESCALE_EN, `prescale_div`=2, `en`=1 -> `count` advances every 3rd cycle; `en`=0 for 2 cycles mid-period -> phase preserved; load -> prescaler restarts.
